// File: rtl/alu_operand_stage.sv
// ALU operand stage: builds the A/B pair from register data or an extended offset,
// with a valid/ready handshake and a 2-entry skid. Macro ALU_OPERAND_STAGE_FWD_EN enables write-back forwarding.
module alu_operand_stage #(
    parameter int DATA_W = 16,
    parameter int OFFS_W = 8,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              en_in,
    output logic              ready_out,
    input  logic [DATA_W-1:0] rd_q,
    input  logic [DATA_W-1:0] rs_q,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [OFFS_W-1:0] offset_addr,
    input  logic [1:0]        alu_in_sel,
    input  logic              fwd_we,
    input  logic [REG_AW-1:0] fwd_addr,
    input  logic [DATA_W-1:0] fwd_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              en_out,
    input  logic              alu_ready
);

    // Handshake: a beat moves upstream when en_in && ready_out, downstream when en_out && alu_ready.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t state;

    logic [DATA_W-1:0]        skid_a;
    logic [DATA_W-1:0]        skid_b;
    logic [DATA_W-1:0]        rd_v;
    logic [DATA_W-1:0]        rs_v;
    logic [DATA_W-1:0]        zext;
    logic [DATA_W-1:0]        sext;
    logic [DATA_W-1:0]        op_a;
    logic [DATA_W-1:0]        op_b;
    logic signed [OFFS_W-1:0] offs_s;
    logic                     accept;
    logic                     transfer;

    assign en_out    = (state != ST_EMPTY);
    assign ready_out = (state != ST_SKID);
    assign accept    = en_in && ready_out;
    assign transfer  = en_out && alu_ready;

`ifdef ALU_OPERAND_STAGE_FWD_EN
    assign rd_v = (fwd_we && (fwd_addr == rd_addr)) ? fwd_data : rd_q;
    assign rs_v = (fwd_we && (fwd_addr == rs_addr)) ? fwd_data : rs_q;
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_we, fwd_addr, fwd_data, rd_addr, rs_addr};
    assign rd_v = rd_q;
    assign rs_v = rs_q;
`endif

    // Size casts extend according to signedness, and are identity when OFFS_W == DATA_W.
    assign offs_s = offset_addr;
    assign zext   = DATA_W'(offset_addr);
    assign sext   = DATA_W'(offs_s);

    always_comb begin
        op_a = rd_v;
        op_b = zext;
        case (alu_in_sel)
            2'd0: begin op_a = rd_v;         op_b = zext; end
            2'd1: begin op_a = rd_v;         op_b = rs_v; end
            2'd2: begin op_a = rd_v;         op_b = sext; end
            2'd3: begin op_a = '0;           op_b = rs_v; end
            default: begin op_a = rd_v;      op_b = zext; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= ST_EMPTY;
            alu_a  <= '0;
            alu_b  <= '0;
            skid_a <= '0;
            skid_b <= '0;
        end else if (flush) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        alu_a <= op_a;
                        alu_b <= op_b;
                        state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (accept && transfer) begin
                        alu_a <= op_a;
                        alu_b <= op_b;
                    end else if (accept) begin
                        skid_a <= op_a;
                        skid_b <= op_b;
                        state  <= ST_SKID;
                    end else if (transfer) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (transfer) begin
                        alu_a <= skid_a;
                        alu_b <= skid_b;
                        state <= ST_FULL;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed steps then random traffic against a queue model.
module tb_alu_operand_stage;
    localparam int DW = 16;
    localparam int OW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst, flush, en_in, ready_out, fwd_we, en_out, alu_ready;
    logic [DW-1:0] rd_q, rs_q, fwd_data, alu_a, alu_b;
    logic [AW-1:0] rd_addr, rs_addr, fwd_addr;
    logic [OW-1:0] offset_addr;
    logic [1:0]    alu_in_sel;

    int            checks = 0;
    int            errors = 0;
    logic [2*DW-1:0] exp_q[$];
    bit            last_accept;

    always #5 clk = ~clk;

    alu_operand_stage #(.DATA_W(DW), .OFFS_W(OW), .REG_AW(AW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .en_in(en_in), .ready_out(ready_out),
        .rd_q(rd_q), .rs_q(rs_q), .rd_addr(rd_addr), .rs_addr(rs_addr),
        .offset_addr(offset_addr), .alu_in_sel(alu_in_sel), .fwd_we(fwd_we),
        .fwd_addr(fwd_addr), .fwd_data(fwd_data), .alu_a(alu_a), .alu_b(alu_b),
        .en_out(en_out), .alu_ready(alu_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference operands from the mode rules, using plain integer arithmetic.
    function automatic logic [2*DW-1:0] model_pair();
        logic [31:0] rdv, rsv, off, a, b;
        rdv = rd_q;
        rsv = rs_q;
`ifdef ALU_OPERAND_STAGE_FWD_EN
        if (fwd_we && fwd_addr == rd_addr) rdv = fwd_data;
        if (fwd_we && fwd_addr == rs_addr) rsv = fwd_data;
`endif
        off = offset_addr;
        case (alu_in_sel)
            2'd0: begin a = rdv; b = off; end
            2'd1: begin a = rdv; b = rsv; end
            2'd2: begin
                a = rdv;
                b = (off >= (32'd1 << (OW - 1))) ? off + (32'd1 << DW) - (32'd1 << OW) : off;
            end
            default: begin a = 0; b = rsv; end
        endcase
        return {a[DW-1:0], b[DW-1:0]};
    endfunction

    // Called at posedge+1 with inputs already driven; checks mid-cycle, then advances the model.
    task automatic tick();
        logic [2*DW-1:0] head, pair;
        bit acc, xfer;
        #4;
        chk("en_out", en_out, exp_q.size() > 0);
        chk("ready_out", ready_out, exp_q.size() < 2);
        if (exp_q.size() > 0) begin
            head = exp_q[0];
            chk("alu_a", alu_a, head[2*DW-1:DW]);
            chk("alu_b", alu_b, head[DW-1:0]);
        end
        acc  = rst && !flush && en_in && (exp_q.size() < 2);
        xfer = (exp_q.size() > 0) && alu_ready;
        pair = model_pair();
        @(posedge clk);
        #1;
        if (!rst || flush) begin
            exp_q.delete();
        end else begin
            if (xfer) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(pair);
        end
        last_accept = acc;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; en_in = 1'b0; alu_ready = 1'b0;
        rd_q = '0; rs_q = '0; rd_addr = '0; rs_addr = '0; offset_addr = '0;
        alu_in_sel = 2'd0; fwd_we = 1'b0; fwd_addr = '0; fwd_data = '0;
        last_accept = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("rst_en_out", en_out, 0);
        chk("rst_ready", ready_out, 1);
        chk("rst_a", alu_a, 0);
        chk("rst_b", alu_b, 0);

        // Mode 0, 2, 3 directed
        rd_q = 16'h1234; offset_addr = 8'h85; alu_in_sel = 2'd0; en_in = 1'b1; alu_ready = 1'b1;
        tick();
        en_in = 1'b0;
        chk("m0_en", en_out, 1);
        chk("m0_a", alu_a, 16'h1234);
        chk("m0_b", alu_b, 16'h0085);
        tick();
        alu_in_sel = 2'd2; en_in = 1'b1;
        tick();
        en_in = 1'b0;
        chk("m2_b", alu_b, 16'hFF85);
        rs_q = 16'h00AA; alu_in_sel = 2'd3; en_in = 1'b1;
        tick();
        en_in = 1'b0;
        chk("m3_a", alu_a, 16'h0000);
        chk("m3_b", alu_b, 16'h00AA);
        tick();

        // Back-pressure: three offers, two accepted
        alu_ready = 1'b0; alu_in_sel = 2'd1; en_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_q = 16'h1000 + 16'(i); rs_q = 16'h2000 + 16'(i);
            tick();
        end
        chk("bp_ready_low", ready_out, 0);
        // rst pulse between edges must not disturb anything
        rst = 1'b0;
        #2;
        chk("async_en", en_out, 1);
        chk("async_ready", ready_out, 0);
        chk("async_a", alu_a, 16'h1000);
        rst = 1'b1;
        alu_ready = 1'b1;
        begin
            int n = 0;
            do begin tick(); n++; end while (!last_accept && n < 10);
            if (!last_accept) begin
                checks++; errors++;
                $error("FAIL bp_third_offer observed=not_accepted expected=accepted");
            end
        end
        en_in = 1'b0;
        repeat (3) tick();

        // Flush while in SKID with a same-cycle offer
        alu_ready = 1'b0; en_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rd_q = 16'h3000 + 16'(i);
            tick();
        end
        flush = 1'b1; rd_q = 16'h7777;
        tick();
        flush = 1'b0; en_in = 1'b0;
        chk("flush_en", en_out, 0);
        chk("flush_ready", ready_out, 1);
        alu_ready = 1'b1;
        repeat (3) tick();

        // Synchronous reset mid-stall
        alu_ready = 1'b0; en_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rd_q = 16'h5000 + 16'(i);
            tick();
        end
        rst = 1'b0; en_in = 1'b0;
        tick();
        rst = 1'b1;
        chk("mrst_en", en_out, 0);
        chk("mrst_ready", ready_out, 1);
        chk("mrst_a", alu_a, 0);
        chk("mrst_b", alu_b, 0);
        alu_ready = 1'b1;
        repeat (2) tick();

        // Forwarding
        rd_addr = 3'd3; rd_q = 16'h0001; rs_addr = 3'd5; rs_q = 16'h0042;
        fwd_we = 1'b1; fwd_addr = 3'd3; fwd_data = 16'hBEEF; alu_in_sel = 2'd1; en_in = 1'b1;
        tick();
        en_in = 1'b0; fwd_we = 1'b0;
`ifdef ALU_OPERAND_STAGE_FWD_EN
        chk("fwd_a", alu_a, 16'hBEEF);
`else
        chk("fwd_a", alu_a, 16'h0001);
`endif
        chk("fwd_b", alu_b, 16'h0042);
        tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            en_in       = ($urandom_range(0, 3) != 0);
            alu_ready   = ($urandom_range(0, 2) != 0);
            flush       = ($urandom_range(0, 31) == 0);
            rst         = ($urandom_range(0, 63) != 0);
            rd_q        = DW'($urandom);
            rs_q        = DW'($urandom);
            fwd_data    = DW'($urandom);
            offset_addr = OW'($urandom);
            alu_in_sel  = 2'($urandom_range(0, 3));
            rd_addr     = AW'($urandom_range(0, 7));
            rs_addr     = AW'($urandom_range(0, 7));
            fwd_addr    = AW'($urandom_range(0, 7));
            fwd_we      = ($urandom_range(0, 1) != 0);
            tick();
        end
        rst = 1'b1; flush = 1'b0; en_in = 1'b0; alu_ready = 1'b1;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
